// File: rtl/sparse_mac_job_seq.sv
// sparse_mac_job_seq: job sequencer that streams per-lane SRAM entries into sparse_mac_top
// and returns the single accumulated result with the job tag, guarded by a watchdog.
module sparse_mac_job_seq #(
    parameter int NUM_DECODERS = 2,
    parameter int ADDR_W       = 10,
    parameter int LEN_W        = 8,
    parameter int TAG_W        = 4,
    parameter int TIMEOUT_CYC  = 1024,
    parameter int DATA_W       = 16,
    parameter int ACCUM_W      = 32
) (
    input  logic                                 mac_clk,
    input  logic                                 mac_rst_n,
    input  logic                                 cmd_valid_i,
    output logic                                 cmd_ready_o,
    input  logic [NUM_DECODERS*ADDR_W-1:0]       cmd_base_i,
    input  logic [NUM_DECODERS*LEN_W-1:0]        cmd_len_i,
    input  logic [TAG_W-1:0]                     cmd_tag_i,
    output logic [NUM_DECODERS-1:0]              sram_rd_en_o,
    output logic [NUM_DECODERS*ADDR_W-1:0]       sram_rd_addr_o,
    input  logic [NUM_DECODERS-1:0][DATA_W-1:0]  sram_rd_data_i,
    output logic [NUM_DECODERS-1:0]              mac_sram_valid_o,
    input  logic [NUM_DECODERS-1:0]              mac_sram_ready_i,
    output logic [NUM_DECODERS-1:0][DATA_W-1:0]  mac_sram_data_o,
    input  logic                                 mac_valid_i,
    input  logic [ACCUM_W-1:0]                   mac_data_i,
    output logic                                 res_valid_o,
    input  logic                                 res_ready_i,
    output logic [ACCUM_W-1:0]                   res_data_o,
    output logic [TAG_W-1:0]                     res_tag_o,
    output logic                                 res_err_o,
    output logic                                 busy_o,
    output logic                                 spurious_o,
    output logic [15:0]                          jobs_done_o
);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT, RESULT} state_t;
    state_t state, state_n;

    logic [NUM_DECODERS*ADDR_W-1:0] base_q;
    logic [NUM_DECODERS*LEN_W-1:0]  len_q;
    logic [WD_W-1:0]                wd_q;
    logic                           captured_q;
    logic [NUM_DECODERS-1:0]        lane_done;
    logic accept, active, cap_now, cap_any, expire, all_done;

    assign accept   = cmd_valid_i && state == IDLE;
    assign active   = state == STREAM || state == WAIT;
    assign cap_now  = active && mac_valid_i && !captured_q;
    assign cap_any  = captured_q || cap_now;
    assign expire   = active && wd_q == WD_LAST;
    assign all_done = &lane_done;

    always_comb begin
        state_n     = state;
        cmd_ready_o = state == IDLE;
        busy_o      = state != IDLE;
        res_valid_o = state == RESULT;
        case (state)
            IDLE:    if (accept) state_n = STREAM;
            STREAM:  if (expire || (all_done && cap_any)) state_n = RESULT;
                     else if (all_done) state_n = WAIT;
            WAIT:    if (expire || cap_any) state_n = RESULT;
            RESULT:  if (res_ready_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge mac_clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            state       <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            wd_q        <= '0;
            captured_q  <= 1'b0;
            res_data_o  <= '0;
            res_tag_o   <= '0;
            res_err_o   <= 1'b0;
            spurious_o  <= 1'b0;
            jobs_done_o <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                base_q     <= cmd_base_i;
                len_q      <= cmd_len_i;
                res_tag_o  <= cmd_tag_i;
                wd_q       <= '0;
                captured_q <= 1'b0;
                res_data_o <= '0;
                res_err_o  <= 1'b0;
            end
            if (active) wd_q <= wd_q + 1'b1;
            if (cap_now) begin
                captured_q <= 1'b1;
                res_data_o <= mac_data_i;
            end
            // A capture landing in the expiry cycle still counts as a good result
            if (active && state_n == RESULT) res_err_o <= !cap_any;
            if (mac_valid_i && (state == IDLE || state == RESULT)) spurious_o <= 1'b1;
            if (res_valid_o && res_ready_i) jobs_done_o <= jobs_done_o + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_DECODERS; g++) begin : g_lane
        logic [LEN_W-1:0]  issued, len;
        logic [ADDR_W-1:0] base;
        logic [DATA_W-1:0] mem [2];
        logic [1:0]        cnt, occ;
        logic              pend, rp, wp, pop, issue, flush;
        assign len   = len_q[g*LEN_W +: LEN_W];
        assign base  = base_q[g*ADDR_W +: ADDR_W];
        assign flush = state != STREAM || expire;
        assign pop   = mac_sram_valid_o[g] && mac_sram_ready_i[g];
        // Occupancy after this cycle's pop, counting the read still in flight
        assign occ   = cnt + {1'b0, pend} - {1'b0, pop};
        assign issue = !flush && issued < len && occ < 2'd2;
        assign sram_rd_en_o[g] = issue;
        assign sram_rd_addr_o[g*ADDR_W +: ADDR_W] = issue ? base + ADDR_W'(issued) : '0;
        assign mac_sram_valid_o[g] = cnt != 2'd0;
        assign mac_sram_data_o[g]  = cnt != 2'd0 ? mem[rp] : '0;
        assign lane_done[g] = issued == len && !pend && cnt == 2'd0;
        always_ff @(posedge mac_clk or negedge mac_rst_n) begin
            if (!mac_rst_n) begin
                issued <= '0;
                pend   <= 1'b0;
                cnt    <= '0;
                rp     <= 1'b0;
                wp     <= 1'b0;
                mem[0] <= '0;
                mem[1] <= '0;
            end else if (flush) begin
                pend <= 1'b0;
                cnt  <= '0;
                rp   <= 1'b0;
                wp   <= 1'b0;
                if (accept) issued <= '0;
            end else begin
                pend <= issue;
                cnt  <= occ;
                if (issue) issued <= issued + 1'b1;
                if (pend) begin
                    mem[wp] <= sram_rd_data_i[g];
                    wp      <= !wp;
                end
                if (pop) rp <= !rp;
            end
        end
    end
endmodule

// File: tb/tb_sparse_mac_job_seq.sv
// tb_sparse_mac_job_seq: table-driven and randomized jobs against an SRAM/MAC model;
// beats and addresses are compared with sequences derived from base/len per lane.
module tb_sparse_mac_job_seq;
    localparam int TO = 16;

    logic              mac_clk, mac_rst_n;
    logic              cmd_valid_i, cmd_ready_o;
    logic [19:0]       cmd_base_i;
    logic [15:0]       cmd_len_i;
    logic [3:0]        cmd_tag_i;
    logic [1:0]        sram_rd_en_o;
    logic [19:0]       sram_rd_addr_o;
    logic [1:0][15:0]  sram_rd_data_i;
    logic [1:0]        mac_sram_valid_o, mac_sram_ready_i;
    logic [1:0][15:0]  mac_sram_data_o;
    logic              mac_valid_i;
    logic [31:0]       mac_data_i;
    logic              res_valid_o, res_ready_i, res_err_o, busy_o, spurious_o;
    logic [31:0]       res_data_o;
    logic [3:0]        res_tag_o;
    logic [15:0]       jobs_done_o;

    sparse_mac_job_seq #(.NUM_DECODERS(2), .ADDR_W(10), .LEN_W(8), .TAG_W(4),
                         .TIMEOUT_CYC(TO), .DATA_W(16), .ACCUM_W(32)) dut (
        .mac_clk(mac_clk), .mac_rst_n(mac_rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_base_i(cmd_base_i),
        .cmd_len_i(cmd_len_i), .cmd_tag_i(cmd_tag_i),
        .sram_rd_en_o(sram_rd_en_o), .sram_rd_addr_o(sram_rd_addr_o), .sram_rd_data_i(sram_rd_data_i),
        .mac_sram_valid_o(mac_sram_valid_o), .mac_sram_ready_i(mac_sram_ready_i),
        .mac_sram_data_o(mac_sram_data_o), .mac_valid_i(mac_valid_i), .mac_data_i(mac_data_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .res_tag_o(res_tag_o), .res_err_o(res_err_o), .busy_o(busy_o),
        .spurious_o(spurious_o), .jobs_done_o(jobs_done_o)
    );

    typedef struct {
        logic [9:0]  b0, b1;
        logic [7:0]  l0, l1;
        logic [3:0]  tag;
        int          mode;      // 0 ready high, 1 lane0 toggles, 2 random
        int          fm;        // 0 never, 1 d cycles after lanes drained, 2 at cycle d
        int          d;
        bit          dup;
        int          hold;
        logic [31:0] data;
        bit          exp_err;
        logic [31:0] exp_data;
        int          exp_cyc;   // 0 = latency not checked
    } job_t;

    int passed = 0, total = 0, exp_jobs = 0, cyc = 0;
    logic [9:0]  aq [2][$];
    logic [15:0] bq [2][$];
    int          bcyc [2][$];
    int          n_iss [2], n_tak [2], max_out [2];
    logic [1:0][15:0] nxt;

    initial mac_clk = 1'b0;
    always #5 mac_clk = ~mac_clk;

    function automatic logic [15:0] fdat(int lane, logic [9:0] a);
        return {4'(lane), 2'b00, a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // SRAM model: data for a read is presented through the whole following cycle
    always @(posedge mac_clk) begin
        #1 sram_rd_data_i = nxt;
    end

    always @(negedge mac_clk) begin
        cyc++;
        if (mac_rst_n)
            for (int i = 0; i < 2; i++) begin
                nxt[i] = sram_rd_en_o[i] ? fdat(i, sram_rd_addr_o[i*10 +: 10]) : 16'($urandom);
                if (sram_rd_en_o[i]) begin
                    aq[i].push_back(sram_rd_addr_o[i*10 +: 10]);
                    n_iss[i]++;
                end
                if (mac_sram_valid_o[i] && mac_sram_ready_i[i]) begin
                    bq[i].push_back(mac_sram_data_o[i]);
                    bcyc[i].push_back(cyc);
                    n_tak[i]++;
                end
                if (n_iss[i] - n_tak[i] > max_out[i]) max_out[i] = n_iss[i] - n_tak[i];
            end
    end

    task automatic run_job(input job_t j, output logic [31:0] r_data, output logic r_err,
                           output logic [3:0] r_tag, output int r_cyc, output bit fired);
        int cdone, fire_c, bad;
        bit got, fire;
        cdone = -1; fire_c = -10; got = 0; fired = 0; r_cyc = -1;
        r_data = '0; r_err = 1'b0; r_tag = '0;
        for (int i = 0; i < 2; i++) begin
            aq[i].delete(); bq[i].delete(); bcyc[i].delete();
            n_iss[i] = 0; n_tak[i] = 0; max_out[i] = 0;
        end
        chk("cmd_ready_idle", cmd_ready_o, 1);
        cmd_base_i = {j.b1, j.b0}; cmd_len_i = {j.l1, j.l0}; cmd_tag_i = j.tag; cmd_valid_i = 1'b1;
        @(posedge mac_clk); #1;
        cmd_valid_i = 1'b0;
        chk("busy_after_accept", busy_o, 1);
        for (int c = 0; c < 40; c++) begin
            if (cdone < 0 && bq[0].size() >= int'(j.l0) && bq[1].size() >= int'(j.l1)) cdone = c;
            fire = !fired && c <= TO - 1 &&
                   ((j.fm == 1 && cdone >= 0 && c >= cdone + j.d) || (j.fm == 2 && c == j.d));
            case (j.mode)
                0:       mac_sram_ready_i = 2'b11;
                1:       mac_sram_ready_i = {1'b1, c % 2 == 0};
                default: mac_sram_ready_i = {$urandom_range(3) != 0, $urandom_range(3) != 0};
            endcase
            mac_valid_i = fire || (j.dup && fired && c == fire_c + 1);
            mac_data_i  = fire ? j.data : ~j.data;
            if (fire) begin
                fired = 1; fire_c = c;
            end
            @(negedge mac_clk);
            if (res_valid_o) begin
                got = 1; r_cyc = c;
                break;
            end
            @(posedge mac_clk); #1;
        end
        mac_valid_i = 1'b0;
        #1;
        if (!got) begin
            chk("res_arrival", got, 1);
            return;
        end
        r_data = res_data_o; r_err = res_err_o; r_tag = res_tag_o;
        bad = 0;
        repeat (j.hold) begin
            @(negedge mac_clk);
            if (res_valid_o !== 1'b1 || res_data_o !== r_data || res_err_o !== r_err || res_tag_o !== r_tag) bad++;
        end
        if (j.hold > 0) chk("res_stable", bad, 0);
        res_ready_i = 1'b1;
        @(posedge mac_clk); #1;
        res_ready_i = 1'b0;
        exp_jobs++;
        @(negedge mac_clk);
        chk("jobs_done", jobs_done_o, 16'(exp_jobs));
        chk("back_to_idle", {cmd_ready_o, res_valid_o}, 2'b10);
    endtask

    task automatic check_lanes(input job_t j, input bit err);
        int len, bad;
        logic [9:0] b, a;
        for (int i = 0; i < 2; i++) begin
            len = (i == 0) ? int'(j.l0) : int'(j.l1);
            b = (i == 0) ? j.b0 : j.b1;
            bad = 0;
            for (int k = 0; k < bq[i].size(); k++) begin
                a = b + 10'(k);
                if (k >= len || bq[i][k] !== fdat(i, a)) bad++;
            end
            for (int k = 0; k < aq[i].size(); k++) begin
                a = b + 10'(k);
                if (k >= len || aq[i][k] !== a) bad++;
            end
            chk($sformatf("lane%0d_order", i), bad, 0);
            if (!err) chk($sformatf("lane%0d_beats", i), bq[i].size(), len);
            if (!err && j.mode == 0 && len > 0 && bcyc[i].size() == len)
                chk($sformatf("lane%0d_back2back", i), bcyc[i][len-1] - bcyc[i][0], len - 1);
            chk($sformatf("lane%0d_outstanding", i), max_out[i] > 2, 0);
        end
    endtask

    job_t tbl [8];
    job_t rj;
    logic [31:0] rd;
    logic        re;
    logic [3:0]  rt;
    int          rc;
    bit          fd;

    initial begin
        tbl[0] = '{10'h010, 10'h200, 8'd3, 8'd3, 4'h5, 0, 1, 0, 1'b0, 0, 32'h0000_1234, 1'b0, 32'h0000_1234, 6};
        tbl[1] = '{10'h040, 10'h080, 8'd5, 8'd2, 4'h6, 1, 1, 1, 1'b0, 0, 32'hABCD_0001, 1'b0, 32'hABCD_0001, 0};
        tbl[2] = '{10'h100, 10'h150, 8'd0, 8'd4, 4'h7, 0, 1, 0, 1'b0, 0, 32'h0000_BEEF, 1'b0, 32'h0000_BEEF, 0};
        tbl[3] = '{10'h020, 10'h030, 8'd3, 8'd1, 4'h8, 0, 0, 0, 1'b0, 0, 32'hDEAD_DEAD, 1'b1, 32'h0,         16};
        tbl[4] = '{10'h3FE, 10'h3FF, 8'd4, 8'd2, 4'h9, 0, 1, 2, 1'b0, 0, 32'h5555_AAAA, 1'b0, 32'h5555_AAAA, 0};
        tbl[5] = '{10'h001, 10'h002, 8'd3, 8'd3, 4'hA, 0, 2, 0, 1'b1, 0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 0};
        tbl[6] = '{10'h005, 10'h006, 8'd2, 8'd2, 4'hB, 0, 2, 15, 1'b0, 0, 32'h0F0F_0F0F, 1'b0, 32'h0F0F_0F0F, 16};
        tbl[7] = '{10'h000, 10'h000, 8'd0, 8'd0, 4'hC, 0, 1, 3, 1'b0, 10, 32'h7777_0000, 1'b0, 32'h7777_0000, 4};

        mac_rst_n = 1'b0; cmd_valid_i = 1'b0; cmd_base_i = '0; cmd_len_i = '0; cmd_tag_i = '0;
        sram_rd_data_i = '0; mac_sram_ready_i = 2'b11; mac_valid_i = 1'b0; mac_data_i = '0;
        res_ready_i = 1'b0; nxt = '0;
        repeat (3) @(posedge mac_clk);
        @(negedge mac_clk);
        mac_rst_n = 1'b1;
        @(negedge mac_clk);
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_res", {res_valid_o, res_err_o, res_data_o, res_tag_o}, 0);
        chk("rst_lanes", {sram_rd_en_o, mac_sram_valid_o, sram_rd_addr_o}, 0);
        chk("rst_counters", {spurious_o, jobs_done_o}, 0);

        for (int t = 0; t < 8; t++) begin
            run_job(tbl[t], rd, re, rt, rc, fd);
            chk($sformatf("t%0d_res_data", t), rd, tbl[t].exp_data);
            chk($sformatf("t%0d_res_err", t), re, tbl[t].exp_err);
            chk($sformatf("t%0d_res_tag", t), rt, tbl[t].tag);
            if (tbl[t].exp_cyc > 0) chk($sformatf("t%0d_latency", t), rc, tbl[t].exp_cyc);
            check_lanes(tbl[t], tbl[t].exp_err);
        end

        // Random jobs: a result is good exactly when the MAC answered within the watchdog window
        for (int n = 0; n < 20; n++) begin
            rj.b0 = 10'($urandom); rj.b1 = 10'($urandom);
            rj.l0 = 8'($urandom_range(3)); rj.l1 = 8'($urandom_range(3));
            rj.tag = 4'($urandom); rj.mode = 2; rj.fm = 1; rj.d = $urandom_range(2);
            rj.dup = 1'b0; rj.hold = $urandom_range(2); rj.data = $urandom;
            run_job(rj, rd, re, rt, rc, fd);
            chk("rnd_res_err", re, !fd);
            chk("rnd_res_data", rd, fd ? rj.data : 32'h0);
            chk("rnd_res_tag", rt, rj.tag);
            check_lanes(rj, !fd);
        end

        chk("no_spurious_yet", spurious_o, 0);
        mac_valid_i = 1'b1;
        @(posedge mac_clk); #1;
        mac_valid_i = 1'b0;
        @(negedge mac_clk);
        chk("spurious_idle", {spurious_o, cmd_ready_o, busy_o}, 3'b110);

        cmd_base_i = {10'h100, 10'h100}; cmd_len_i = {8'd5, 8'd5}; cmd_valid_i = 1'b1;
        mac_sram_ready_i = 2'b11;
        @(posedge mac_clk); #1;
        cmd_valid_i = 1'b0;
        @(posedge mac_clk); #3;
        chk("mid_stream_rd_en", sram_rd_en_o, 2'b11);
        mac_rst_n = 1'b0;
        #1;
        chk("async_rst_ready", {cmd_ready_o, busy_o}, 2'b10);
        chk("async_rst_lanes", {sram_rd_en_o, mac_sram_valid_o, sram_rd_addr_o}, 0);
        chk("async_rst_res", {res_valid_o, res_err_o, spurious_o, jobs_done_o}, 0);
        @(negedge mac_clk);
        mac_rst_n = 1'b1;
        exp_jobs = 0;
        @(negedge mac_clk);
        chk("post_rst_quiet", {sram_rd_en_o, mac_sram_valid_o, res_valid_o}, 0);
        run_job(tbl[0], rd, re, rt, rc, fd);
        chk("post_rst_job", {re, rt, rd}, {1'b0, tbl[0].tag, tbl[0].exp_data});
        check_lanes(tbl[0], 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sparse_mac_job_seq.md
Name: sparse_mac_job_seq

Overview:
Job sequencer in front of sparse_mac_top. Accepts one dot-product job at a time. Each job is a base address and length per decoder lane. The block streams the SRAM entries of every lane into the MAC's per-lane ready/valid inputs, captures the single accumulated result, and returns it with the job tag. A watchdog terminates jobs whose MAC result never arrives.

Parameters:
NUM_DECODERS, 2, number of lanes; must match the sparse_mac_top instance.
ADDR_W, 10, SRAM word address width per lane.
LEN_W, 8, per-lane entry count width; 0 is legal.
TAG_W, 4, job tag width, returned unchanged with the result.
TIMEOUT_CYC, 1024, maximum cycles from job accept to result capture; must be ≥2.

Ports:
mac_clk  in  1  clock; all logic rises on the posedge.
mac_rst_n  in  1  asynchronous, active-low reset.
cmd_valid_i  in  1  job command valid.
cmd_ready_o  out  1  job command ready; high only in IDLE.
cmd_base_i  in  NUM_DECODERS*ADDR_W  per-lane start address; lane i occupies bits [i*ADDR_W +: ADDR_W].
cmd_len_i  in  NUM_DECODERS*LEN_W  per-lane entry count.
cmd_tag_i  in  TAG_W  job tag.
sram_rd_en_o  out  NUM_DECODERS  per-lane SRAM read strobe.
sram_rd_addr_o  out  NUM_DECODERS*ADDR_W  per-lane read address.
sram_rd_data_i  in  NUM_DECODERS x sram_data_t  read data; valid exactly 1 cycle after rd_en.
mac_sram_valid_o  out  NUM_DECODERS  drives sparse_mac_top sram_valid_i.
mac_sram_ready_i  in  NUM_DECODERS  from sparse_mac_top sram_ready_o.
mac_sram_data_o  out  NUM_DECODERS x sram_data_t  drives sparse_mac_top sram_data_i.
mac_valid_i  in  1  from sparse_mac_top mac_valid_o.
mac_data_i  in  ACCUM_W  from sparse_mac_top mac_data_o.
res_valid_o  out  1  result valid.
res_ready_i  in  1  result ready.
res_data_o  out  ACCUM_W  captured accumulator value; 0 on error.
res_tag_o  out  TAG_W  tag of the job.
res_err_o  out  1  job ended by timeout.
busy_o  out  1  high in any state other than IDLE.
spurious_o  out  1  sticky; set when mac_valid_i arrives in IDLE or RESULT; cleared only by reset.
jobs_done_o  out  16  count of results handed off; wraps 0xFFFF→0.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; all outputs 0 except cmd_ready_o=1; lane buffers empty; counters 0.
- FSM states: IDLE, STREAM, WAIT, RESULT.
  - IDLE: cmd_valid_i && cmd_ready_o latches base, len and tag, clears the watchdog and result-captured flag, then goes to STREAM.
  - STREAM → WAIT when every lane is done.
  - WAIT → RESULT when a result has been captured.
  - STREAM or WAIT → RESULT on watchdog expiry.
  - RESULT → IDLE on res_valid_o && res_ready_i.
- Lane engine (one per lane, active only in STREAM):
  - Per-lane 2-entry FIFO plus in-flight counter.
  - Issue a read (rd_en=1, addr=base+issued) when issued<len and occupancy+in_flight<2.
  - Data returns the next cycle and is pushed into the FIFO.
  - FIFO head drives mac_sram_valid_o/data_o; pop when valid&&ready.
  - Sustained throughput is 1 entry/cycle per lane with ready held high.
  - Address arithmetic is modulo 2^ADDR_W (wraps, no error).
  - Lane done when issued==len, in_flight==0 and FIFO empty.
  - A len=0 lane is done immediately and never asserts rd_en or valid.
- Handshake rules:
  - mac_sram_valid_o stays high with data stable until ready; it never drops without a transfer.
  - res_valid_o stays high with all res_* stable until res_ready_i.
- Result capture: mac_valid_i in STREAM or WAIT stores mac_data_i and sets captured. A second mac_valid_i in the same job is ignored.
- Result capture runs in parallel with lane drain: a result captured early in STREAM still waits for all lanes done before RESULT.
- Watchdog: counts every cycle in STREAM/WAIT. At TIMEOUT_CYC with no capture it enters RESULT with res_err_o=1 and res_data_o=0. Lane engines flush (FIFOs cleared, in-flight reads discarded).
- Simultaneous events:
  - Capture in the same cycle as expiry: capture wins, res_err_o=0.
  - Capture in the same cycle all lanes complete in STREAM: go directly to RESULT.
- jobs_done_o increments on each result handshake, including error results.
- Reset mid-job: abandons everything immediately. No rd_en, valid or res_valid is asserted in the cycle after reset release.

Test Plan:
1. Single job, NUM_DECODERS=2, base={0x010,0x200}, len={3,3}, mac_ready held high:
   - rd_en addresses are 0x010–0x012 and 0x200–0x202.
   - 3 valid beats per lane in 3 consecutive cycles.
   - mac_valid_i with data 0x1234 → res_data_o=0x1234, tag echoed, err=0, jobs_done_o=1.
2. Backpressure: lane 0 ready toggles 1/0 each cycle, len=5 → exactly 5 beats, data order preserved, never more than 2 reads outstanding, no data lost.
3. len={0,4} → lane 0 never asserts rd_en or valid; job completes normally.
4. Timeout with TIMEOUT_CYC=16 and no mac_valid_i → res_valid_o exactly 16 cycles after accept with res_err_o=1 and res_data_o=0; the next job runs cleanly.
5. Address wrap, ADDR_W=10, base=0x3FE, len=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001.
6. Boundary and reset cases:
   - mac_valid_i in IDLE → spurious_o=1, state unchanged.
   - res_ready_i held low 10 cycles → result stable throughout.
   - mac_rst_n asserted mid-STREAM → all outputs 0 and cmd_ready_o=1 asynchronously.
